// File: rtl/gpr_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpr_file
// Purpose  : General-purpose register file with two combinational read ports,
//            one write port, and a per-register pending ("busy") scoreboard.
//            Register 0 is hard-wired to zero and is never busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN   : register width in bits (>= 8)
//   NREG   : number of registers (power of two, 2..64)
//   BYPASS : 1 = forward a same-cycle write to matching read ports, 0 = none
// Ports
//   i_clock              : clock, all state updates on rising edge
//   i_resetn             : asynchronous active-low reset
//   i_rs1Addr/o_rs1Data  : read port 1 address / data
//   o_rs1Busy            : read port 1 register awaiting writeback
//   i_rs2Addr/o_rs2Data  : read port 2 address / data
//   o_rs2Busy            : read port 2 register awaiting writeback
//   i_rdWe/i_rdAddr/i_rdData : write enable / address / data
//   i_rsvValid/i_rsvAddr : mark a register as pending
//   i_flush              : clear every pending mark
//   o_busyVec            : registered pending bits (no forwarding), bit 0 = 0
// ============================================================================
module gpr_file #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            i_clock,
  input  logic            i_resetn,
  input  logic [AW-1:0]   i_rs1Addr,
  output logic [XLEN-1:0] o_rs1Data,
  output logic            o_rs1Busy,
  input  logic [AW-1:0]   i_rs2Addr,
  output logic [XLEN-1:0] o_rs2Data,
  output logic            o_rs2Busy,
  input  logic            i_rdWe,
  input  logic [AW-1:0]   i_rdAddr,
  input  logic [XLEN-1:0] i_rdData,
  input  logic            i_rsvValid,
  input  logic [AW-1:0]   i_rsvAddr,
  input  logic            i_flush,
  output logic [NREG-1:0] o_busyVec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic wr_en;
  logic rsv_en;
  logic fwd1;
  logic fwd2;

  // Writes and reserves aimed at register 0 are dropped here, so nothing
  // downstream needs to special-case address 0 for state updates.
  always_comb begin
    wr_en  = i_rdWe && (i_rdAddr != '0);
    rsv_en = i_rsvValid && (i_rsvAddr != '0);
  end

  // Data write: flush and reserve never block a write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[i_rdAddr] = i_rdData;
    end
    regs_d[0] = '0;
  end

  // Pending bits: flush beats reserve, reserve beats writeback, so a reserve
  // and a write to the same register leave it pending (new producer wins).
  always_comb begin
    busy_d = busy_q;
    for (int a = 1; a < NREG; a++) begin
      if (i_flush) begin
        busy_d[a] = 1'b0;
      end else if (rsv_en && (i_rsvAddr == AW'(a))) begin
        busy_d[a] = 1'b1;
      end else if (wr_en && (i_rdAddr == AW'(a))) begin
        busy_d[a] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports. A forwarded write also hides the pending bit, since the
  // consumer is receiving the very value it was waiting for. Outputs are
  // forced to zero while reset is held so a forwarded write cannot leak out.
  always_comb begin
    fwd1 = (BYPASS != 0) && wr_en && (i_rdAddr == i_rs1Addr);
    fwd2 = (BYPASS != 0) && wr_en && (i_rdAddr == i_rs2Addr);

    o_rs1Data = fwd1 ? i_rdData : regs_q[i_rs1Addr];
    o_rs1Busy = busy_q[i_rs1Addr] && !fwd1;
    if (!i_resetn || (i_rs1Addr == '0)) begin
      o_rs1Data = '0;
      o_rs1Busy = 1'b0;
    end

    o_rs2Data = fwd2 ? i_rdData : regs_q[i_rs2Addr];
    o_rs2Busy = busy_q[i_rs2Addr] && !fwd2;
    if (!i_resetn || (i_rs2Addr == '0)) begin
      o_rs2Data = '0;
      o_rs2Busy = 1'b0;
    end
  end

  assign o_busyVec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpr_file
// Purpose  : Self-checking bench for gpr_file. Two 32x32 instances (with and
//            without forwarding) share one stimulus stream and are compared
//            against a behavioural register/scoreboard model; a third 16x64
//            instance exercises wide data and mid-cycle reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the two 32x32 instances
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, ra = '0;
  logic        we = 1'b0, rsv = 1'b0, flush = 1'b0;
  logic [31:0] wdata = '0;

  logic [31:0] b_d1, b_d2, n_d1, n_d2, b_vec, n_vec;
  logic        b_b1, b_b2, n_b1, n_b2;

  // 16x64 instance
  logic        w_rst_n = 1'b0;
  logic [3:0]  w_rs1 = '0, w_rs2 = '0, w_rd = '0, w_ra = '0;
  logic        w_we = 1'b0, w_rsv = 1'b0, w_flush = 1'b0;
  logic [63:0] w_wdata = '0;
  logic [63:0] w_d1, w_d2;
  logic        w_b1, w_b2;
  logic [15:0] w_vec;

  gpr_file #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_b (
    .i_clock(clk), .i_resetn(rst_n),
    .i_rs1Addr(rs1), .o_rs1Data(b_d1), .o_rs1Busy(b_b1),
    .i_rs2Addr(rs2), .o_rs2Data(b_d2), .o_rs2Busy(b_b2),
    .i_rdWe(we), .i_rdAddr(rd), .i_rdData(wdata),
    .i_rsvValid(rsv), .i_rsvAddr(ra), .i_flush(flush),
    .o_busyVec(b_vec)
  );

  gpr_file #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_n (
    .i_clock(clk), .i_resetn(rst_n),
    .i_rs1Addr(rs1), .o_rs1Data(n_d1), .o_rs1Busy(n_b1),
    .i_rs2Addr(rs2), .o_rs2Data(n_d2), .o_rs2Busy(n_b2),
    .i_rdWe(we), .i_rdAddr(rd), .i_rdData(wdata),
    .i_rsvValid(rsv), .i_rsvAddr(ra), .i_flush(flush),
    .o_busyVec(n_vec)
  );

  gpr_file #(.XLEN(64), .NREG(16), .BYPASS(1)) dut_w (
    .i_clock(clk), .i_resetn(w_rst_n),
    .i_rs1Addr(w_rs1), .o_rs1Data(w_d1), .o_rs1Busy(w_b1),
    .i_rs2Addr(w_rs2), .o_rs2Data(w_d2), .o_rs2Busy(w_b2),
    .i_rdWe(w_we), .i_rdAddr(w_rd), .i_rdData(w_wdata),
    .i_rsvValid(w_rsv), .i_rsvAddr(w_ra), .i_flush(w_flush),
    .o_busyVec(w_vec)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_pend = '0;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && rd == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && rd == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic drive(input logic w, input logic [4:0] a_rd, input logic [31:0] d,
                       input logic r, input logic [4:0] a_rs, input logic f,
                       input logic [4:0] a1, input logic [4:0] a2);
    we = w; rd = a_rd; wdata = d; rsv = r; ra = a_rs; flush = f; rs1 = a1; rs2 = a2;
  endtask

  // Advance one clock: update the model at the edge, return on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we && rd != 0) m_mem[rd] = wdata;
      if (flush) begin
        m_pend = '0;
      end else begin
        if (we) m_pend[rd] = 1'b0;
        if (rsv) m_pend[ra] = 1'b1;
        m_pend[0] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_clear();
    // Held in reset: everything reads zero even with a write being offered.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'hA5A5_0000 | i, 1'b1, 5'(i), 1'b0, 5'(i), 5'(31 - i));
      #1;
      checks++;
      if ({b_d1, b_d2, n_d1, n_d2, b_b1, b_b2, b_vec} !== '0) begin
        errors++;
        $display("FAIL in_reset addr=%0d got d1=%h d2=%h vec=%h required 0", i, b_d1, b_d2, b_vec);
      end
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 5'(i), 5'(31 - i));
      #1;
      checks++;
      if ({b_d1, b_d2, n_d1, n_d2, b_b1, b_b2, n_b1, n_b2, b_vec, n_vec} !== '0) begin
        errors++;
        $display("FAIL post_reset addr=%0d got d1=%h d2=%h b1=%b vec=%h required 0", i, b_d1, b_d2, b_b1, b_vec);
      end
      tick();
    end
  endtask

  task automatic test_write_x0();
    drive(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 0); tick();
    drive(1'b1, 0, 32'h1234_5678, 1'b1, 0, 1'b0, 0, 0); tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 5, 0);
    #1;
    checks++;
    if (b_d1 !== 32'hDEAD_BEEF || n_d1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL x5_read got %h/%h required deadbeef", b_d1, n_d1);
    end
    checks++;
    if (b_d2 !== 32'h0 || n_d2 !== 32'h0 || b_b2 !== 1'b0 || b_vec[0] !== 1'b0) begin
      errors++; $display("FAIL x0_read got %h/%h busy=%b required 0", b_d2, n_d2, b_b2);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 7, 32'h11, 1'b0, 0, 1'b0, 0, 0); tick();
    drive(1'b1, 7, 32'h22, 1'b0, 0, 1'b0, 7, 7);
    #1;
    checks++;
    if (b_d1 !== 32'h22 || b_d2 !== 32'h22) begin
      errors++; $display("FAIL bypass_fwd got %h/%h required 22", b_d1, b_d2);
    end
    checks++;
    if (n_d1 !== 32'h11 || n_d2 !== 32'h11) begin
      errors++; $display("FAIL nobypass_old got %h/%h required 11", n_d1, n_d2);
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 7, 7);
    #1;
    checks++;
    if (n_d1 !== 32'h22 || n_d2 !== 32'h22) begin
      errors++; $display("FAIL nobypass_new got %h/%h required 22", n_d1, n_d2);
    end
    tick();
  endtask

  task automatic test_reserve();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 0); tick();
    drive(1'b0, 0, 0, 1'b1, 3, 1'b0, 3, 0);      // cycle N
    #1;
    checks++;
    if (b_b1 !== 1'b0 || n_b1 !== 1'b0) begin
      errors++; $display("FAIL rsv_same_cycle got %b/%b required 0", b_b1, n_b1);
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 3, 0);      // N+1
    #1;
    checks++;
    if (b_b1 !== 1'b1 || n_b1 !== 1'b1 || b_vec[3] !== 1'b1) begin
      errors++; $display("FAIL rsv_next_cycle got %b/%b vec3=%b required 1", b_b1, n_b1, b_vec[3]);
    end
    tick();
    drive(1'b1, 3, 32'hCAFE, 1'b0, 0, 1'b0, 3, 0); // N+2
    #1;
    checks++;
    if (b_b1 !== 1'b0 || n_b1 !== 1'b1 || b_vec[3] !== 1'b1) begin
      errors++; $display("FAIL wb_busy got byp=%b nobyp=%b vec3=%b required 0/1/1", b_b1, n_b1, b_vec[3]);
    end
    tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 3, 0);      // N+3
    #1;
    checks++;
    if (b_vec[3] !== 1'b0 || b_b1 !== 1'b0 || b_d1 !== 32'hCAFE) begin
      errors++; $display("FAIL wb_cleared got vec3=%b busy=%b d=%h required 0/0/cafe", b_vec[3], b_b1, b_d1);
    end
    tick();
  endtask

  task automatic test_rsv_flush();
    drive(1'b1, 4, 32'h55, 1'b1, 4, 1'b0, 4, 0); tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 4, 4);
    #1;
    checks++;
    if (b_d1 !== 32'h55 || b_b1 !== 1'b1 || n_d2 !== 32'h55 || n_b2 !== 1'b1) begin
      errors++; $display("FAIL rsv_wr_same got d=%h busy=%b required 55/1", b_d1, b_b1);
    end
    drive(1'b0, 0, 0, 1'b1, 1, 1'b0, 0, 0); tick();
    drive(1'b0, 0, 0, 1'b1, 2, 1'b0, 0, 0); tick();
    drive(1'b0, 0, 0, 1'b1, 2, 1'b0, 0, 0);       // re-reserve: stays pending
    #1;
    checks++;
    if (b_vec !== 32'h0000_0016) begin
      errors++; $display("FAIL pend_vec got %h required 00000016", b_vec);
    end
    tick();
    drive(1'b1, 2, 32'h9, 1'b1, 5, 1'b1, 0, 0); tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 2, 5);
    #1;
    checks++;
    if (b_vec !== 32'h0 || n_vec !== 32'h0 || b_d1 !== 32'h9 || b_b2 !== 1'b0) begin
      errors++; $display("FAIL flush_write got vec=%h d=%h required 0/9", b_vec, b_d1);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] a_rd;
      a_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), a_rd, $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31)));
      #1;
      checks++;
      if (b_d1 !== exp_data(rs1, 1) || b_d2 !== exp_data(rs2, 1) ||
          b_b1 !== exp_busy(rs1, 1) || b_b2 !== exp_busy(rs2, 1) || b_vec !== m_pend) begin
        errors++;
        $display("FAIL rand_byp cyc=%0d got d1=%h d2=%h b=%b%b vec=%h required d1=%h d2=%h b=%b%b vec=%h",
                 c, b_d1, b_d2, b_b1, b_b2, b_vec, exp_data(rs1, 1), exp_data(rs2, 1),
                 exp_busy(rs1, 1), exp_busy(rs2, 1), m_pend);
      end
      checks++;
      if (n_d1 !== exp_data(rs1, 0) || n_d2 !== exp_data(rs2, 0) ||
          n_b1 !== exp_busy(rs1, 0) || n_b2 !== exp_busy(rs2, 0) || n_vec !== m_pend) begin
        errors++;
        $display("FAIL rand_nobyp cyc=%0d got d1=%h d2=%h b=%b%b vec=%h required d1=%h d2=%h b=%b%b vec=%h",
                 c, n_d1, n_d2, n_b1, n_b2, n_vec, exp_data(rs1, 0), exp_data(rs2, 0),
                 exp_busy(rs1, 0), exp_busy(rs2, 0), m_pend);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    // Reset lands across the edge carrying a write and reserve; both vanish.
    drive(1'b1, 9, 32'h7777, 1'b1, 9, 1'b0, 9, 9);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b_d1 !== 32'h0 || b_vec !== 32'h0) begin
      errors++; $display("FAIL mid_reset_async got d=%h vec=%h required 0", b_d1, b_vec);
    end
    tick();
    model_clear();
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 9, 9);
    #1;
    checks++;
    if (b_d1 !== 32'h0 || b_b1 !== 1'b0 || b_vec !== 32'h0 || n_d2 !== 32'h0) begin
      errors++; $display("FAIL mid_reset_discard got d=%h busy=%b vec=%h required 0", b_d1, b_b1, b_vec);
    end
    // First write after release takes effect on the first edge.
    drive(1'b1, 9, 32'h0BAD_F00D, 1'b0, 0, 1'b0, 9, 9); tick();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 9, 9);
    #1;
    checks++;
    if (n_d1 !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL first_write got %h required 0badf00d", n_d1);
    end
    tick();
  endtask

  task automatic test_wide();
    @(negedge clk);
    w_rst_n = 1'b1;
    w_we = 1'b1; w_rd = 15; w_wdata = 64'hFFFF_FFFF_FFFF_FFFF; w_rsv = 1'b1; w_ra = 9;
    @(posedge clk); @(negedge clk);
    w_we = 1'b0; w_rsv = 1'b0; w_rs1 = 15; w_rs2 = 9;
    #1;
    checks++;
    if (w_d1 !== 64'hFFFF_FFFF_FFFF_FFFF || w_vec !== 16'h0200 || w_b2 !== 1'b1) begin
      errors++; $display("FAIL wide_write got d=%h vec=%h required ffffffffffffffff/0200", w_d1, w_vec);
    end
    w_we = 1'b1; w_rd = 15; w_wdata = 64'h5;
    #1 w_rst_n = 1'b0;
    #1;
    checks++;
    if (w_d1 !== 64'h0 || w_d2 !== 64'h0 || w_vec !== 16'h0 || w_b2 !== 1'b0) begin
      errors++; $display("FAIL wide_async_reset got d1=%h vec=%h required 0", w_d1, w_vec);
    end
    @(posedge clk); @(negedge clk);
    w_wdata = 64'hA5;
    w_rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    w_we = 1'b0;
    #1;
    checks++;
    if (w_d1 !== 64'hA5 || w_d2 !== 64'h0) begin
      errors++; $display("FAIL wide_first_write got d1=%h d2=%h required a5/0", w_d1, w_d2);
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_write_x0();
    test_bypass();
    test_reserve();
    test_rsv_flush();
    test_random();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width in bits (≥8).
REQ-002 SHALL provide parameter NREG, default 32, register count (power of two, 2..64); AW = log2(NREG) is derived internally.
REQ-003 SHALL provide parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_resetn  in  1  asynchronous, active-low reset.
REQ-006 i_rs1Addr  in  AW  read port 1 address.
REQ-007 o_rs1Data  out  XLEN  read port 1 data.
REQ-008 o_rs1Busy  out  1  read port 1 register awaiting writeback.
REQ-009 i_rs2Addr  in  AW  read port 2 address.
REQ-010 o_rs2Data  out  XLEN  read port 2 data.
REQ-011 o_rs2Busy  out  1  read port 2 register awaiting writeback.
REQ-012 i_rdWe  in  1  write enable.
REQ-013 i_rdAddr  in  AW  write address.
REQ-014 i_rdData  in  XLEN  write data.
REQ-015 i_rsvValid  in  1  reserve request: mark i_rsvAddr as pending.
REQ-016 i_rsvAddr  in  AW  register to reserve.
REQ-017 i_flush  in  1  clear all pending marks.
REQ-018 o_busyVec  out  NREG  registered pending bit per register; bit 0 always 0.

Function
REQ-019 Register 0 SHALL read as all-zero with busy 0 on both ports, whatever is written or reserved to it.
REQ-020 On a rising edge with i_rdWe=1 and i_rdAddr≠0, the file SHALL store i_rdData at i_rdAddr; i_rdWe=0 or i_rdAddr=0 SHALL store nothing.
REQ-021 Reads SHALL be combinational, zero latency, and independent on the two ports; both ports reading one address SHALL return identical data.
REQ-022 With BYPASS=1, i_rdWe=1 and i_rdAddr==rsNAddr≠0, the matching port SHALL output i_rdData in the same cycle; with BYPASS=0 it SHALL output the stored value until the next edge.
REQ-023 Each register 1..NREG-1 SHALL have a pending bit; on a rising edge the bit for address a SHALL update with this priority, highest first: i_flush=1 -> 0; i_rsvValid=1 and i_rsvAddr==a -> 1; i_rdWe=1 and i_rdAddr==a -> 0; otherwise hold.
REQ-024 A reserve and a write to the same address in one cycle SHALL store the data and leave the bit set (the new producer wins).
REQ-025 A flush SHALL NOT block a data write in the same cycle; the data SHALL be stored.
REQ-026 o_rsNBusy SHALL equal the pending bit of rsNAddr; with BYPASS=1 it SHALL read 0 when a same-cycle write to that address is present.
REQ-027 A reserve in cycle N SHALL NOT affect o_rsNBusy until cycle N+1.
REQ-028 o_busyVec SHALL show the registered pending bits only, with no bypass.
REQ-029 Reserve or write to address 0 SHALL be ignored with no side effect.
REQ-030 A reserve of an already-pending register SHALL leave it pending, with no counting and no error.

Reset
REQ-031 While i_resetn=0, asynchronously, all registers SHALL be 0, all pending bits 0, o_busyVec=0, and o_rs1Data/o_rs2Data=0 for any address.
REQ-032 The first write SHALL take effect on the first rising edge after i_resetn deasserts.
REQ-033 Reset asserted mid-operation SHALL discard any write or reserve in that cycle.

Verification
REQ-034 Reset, then read every address on both ports -> all data 0, busy 0, o_busyVec=0.
REQ-035 Write 0xDEADBEEF to x5 and 0x12345678 to x0; next cycle rs1=x5, rs2=x0 -> o_rs1Data=0xDEADBEEF, o_rs2Data=0.
REQ-036 BYPASS=1: x7 holds 0x11; same cycle write 0x22 to x7 with rs1=rs2=x7 -> both ports 0x22 that cycle; BYPASS=0 -> 0x11, then 0x22 next cycle.
REQ-037 Reserve x3 in cycle N -> o_rs1Busy(x3)=0 in N, 1 in N+1; write x3 in N+2 -> busy 0 in N+2 (BYPASS=1), o_busyVec[3]=0 in N+3.
REQ-038 Same cycle reserve x4 and write x4=0x55 -> next cycle data 0x55, busy 1; reserve x1, x2, then flush while writing x2=0x9 -> next cycle o_busyVec=0, x2=0x9.
REQ-039 NREG=16, XLEN=64: write 0xFFFF_FFFF_FFFF_FFFF to x15, then assert i_resetn=0 mid-cycle -> x15 reads 0 immediately, o_busyVec=0.
